// File: rtl/keypad_entry_ctrl.sv
// Keypad operand entry controller: press qualification with release lockout,
// hex digit accumulation with edit keys, and valid/ready hand-off of the operand.
module keypad_entry_ctrl #(
   parameter int unsigned DIGITS         = 8,
   parameter int unsigned RELEASE_CYCLES = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [4:0]                     key_code,
   input  logic                           key_strobe,
   input  logic                           out_ready,
   output logic [4*DIGITS-1:0]            out_value,
   output logic                           out_valid,
   output logic [4*DIGITS-1:0]            entry_value,
   output logic [$clog2(DIGITS+1)-1:0]    digit_count,
   output logic                           overflow
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);

   localparam logic [4:0] KEY_ENTER = 5'd16;
   localparam logic [4:0] KEY_BKSP  = 5'd17;
   localparam logic [4:0] KEY_CLEAR = 5'd18;
   localparam logic [4:0] KEY_NEG   = 5'd19;

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      OFLOW = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [RW-1:0]   release_cnt, release_cnt_n;
   logic [W-1:0]    out_value_n, entry_value_n;
   logic [CW-1:0]   digit_count_n;
   logic            out_valid_n, overflow_n;
   logic            armed, key_event;

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ENTRY;
         release_cnt <= RW'(RELEASE_CYCLES);
         out_value   <= '0;
         out_valid   <= 1'b0;
         entry_value <= '0;
         digit_count <= '0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_n;
         release_cnt <= release_cnt_n;
         out_value   <= out_value_n;
         out_valid   <= out_valid_n;
         entry_value <= entry_value_n;
         digit_count <= digit_count_n;
         overflow    <= overflow_n;
      end
   end

   // Press qualification, next-state and next-output logic
   always_comb begin
      armed         = (release_cnt == RW'(RELEASE_CYCLES));
      key_event     = key_strobe && armed;
      state_n       = state;
      out_value_n   = out_value;
      out_valid_n   = out_valid;
      entry_value_n = entry_value;
      digit_count_n = digit_count;
      overflow_n    = overflow;

      // bounce while locked out restarts the lockout window
      if (key_strobe)
         release_cnt_n = '0;
      else if (armed)
         release_cnt_n = release_cnt;
      else
         release_cnt_n = release_cnt + RW'(1);

      case (state)
         ENTRY: begin
            if (key_event) begin
               if (key_code < 5'd16) begin
                  if (digit_count < CW'(DIGITS)) begin
                     entry_value_n = (entry_value << 4) | W'(key_code[3:0]);
                     digit_count_n = digit_count + CW'(1);
                  end else begin
                     overflow_n = 1'b1;
                     state_n    = OFLOW;
                  end
               end else if (key_code == KEY_ENTER) begin
                  if (digit_count != '0) begin
                     out_value_n = entry_value;
                     out_valid_n = 1'b1;
                     state_n     = HOLD;
                  end
               end else if (key_code == KEY_BKSP) begin
                  if (digit_count != '0) begin
                     entry_value_n = entry_value >> 4;
                     digit_count_n = digit_count - CW'(1);
                  end
               end else if (key_code == KEY_CLEAR) begin
                  entry_value_n = '0;
                  digit_count_n = '0;
               end else if (key_code == KEY_NEG) begin
                  if (digit_count != '0)
                     entry_value_n = W'(0) - entry_value;
               end
            end
         end
         OFLOW: begin
            if (key_event && key_code == KEY_CLEAR) begin
               entry_value_n = '0;
               digit_count_n = '0;
               overflow_n    = 1'b0;
               state_n       = ENTRY;
            end
         end
         HOLD: begin
            // key events are swallowed; only the handshake leaves HOLD
            if (out_valid && out_ready) begin
               out_valid_n   = 1'b0;
               entry_value_n = '0;
               digit_count_n = '0;
               state_n       = ENTRY;
            end
         end
         default: state_n = ENTRY;
      endcase
   end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: key-press vector table plus
// hand-written sequences for lockout, handshake and reset-in-HOLD.
module tb_keypad_entry_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  key_code;
   logic        key_strobe;
   logic        out_ready;
   logic [31:0] out_value;
   logic        out_valid;
   logic [31:0] entry_value;
   logic [3:0]  digit_count;
   logic        overflow;

   int vectors = 0;
   int miscompares = 0;

   keypad_entry_ctrl #(.DIGITS(8), .RELEASE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .key_code(key_code), .key_strobe(key_strobe),
      .out_ready(out_ready), .out_value(out_value), .out_valid(out_valid),
      .entry_value(entry_value), .digit_count(digit_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  code;
      logic [31:0] exp_entry;
      logic [3:0]  exp_count;
      logic        exp_ovf;
      logic        exp_valid;
   } vec_t;

   vec_t tbl[26];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // one clean press: one strobe-high cycle, then enough low cycles to re-arm
   task automatic press(input logic [4:0] code);
      key_code   = code;
      key_strobe = 1'b1;
      @(negedge clock);
      key_strobe = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic set_vec(input int i, input logic [4:0] c, input logic [31:0] e,
                          input logic [3:0] n, input logic o, input logic v);
      tbl[i].code = c; tbl[i].exp_entry = e; tbl[i].exp_count = n;
      tbl[i].exp_ovf = o; tbl[i].exp_valid = v;
   endtask

   initial begin
      set_vec(0,  5'd1,  32'h0000_0001, 4'd1, 1'b0, 1'b0);
      set_vec(1,  5'd2,  32'h0000_0012, 4'd2, 1'b0, 1'b0);
      set_vec(2,  5'd10, 32'h0000_012A, 4'd3, 1'b0, 1'b0);
      set_vec(3,  5'd18, 32'h0000_0000, 4'd0, 1'b0, 1'b0);
      set_vec(4,  5'd0,  32'h0000_0000, 4'd1, 1'b0, 1'b0);
      set_vec(5,  5'd5,  32'h0000_0005, 4'd2, 1'b0, 1'b0);
      set_vec(6,  5'd19, 32'hFFFF_FFFB, 4'd2, 1'b0, 1'b0);
      set_vec(7,  5'd17, 32'h0FFF_FFFF, 4'd1, 1'b0, 1'b0);
      set_vec(8,  5'd17, 32'h00FF_FFFF, 4'd0, 1'b0, 1'b0);
      set_vec(9,  5'd17, 32'h00FF_FFFF, 4'd0, 1'b0, 1'b0);
      set_vec(10, 5'd19, 32'h00FF_FFFF, 4'd0, 1'b0, 1'b0);
      set_vec(11, 5'd16, 32'h00FF_FFFF, 4'd0, 1'b0, 1'b0);
      set_vec(12, 5'd25, 32'h00FF_FFFF, 4'd0, 1'b0, 1'b0);
      set_vec(13, 5'd18, 32'h0000_0000, 4'd0, 1'b0, 1'b0);
      set_vec(14, 5'd1,  32'h0000_0001, 4'd1, 1'b0, 1'b0);
      set_vec(15, 5'd2,  32'h0000_0012, 4'd2, 1'b0, 1'b0);
      set_vec(16, 5'd3,  32'h0000_0123, 4'd3, 1'b0, 1'b0);
      set_vec(17, 5'd4,  32'h0000_1234, 4'd4, 1'b0, 1'b0);
      set_vec(18, 5'd5,  32'h0001_2345, 4'd5, 1'b0, 1'b0);
      set_vec(19, 5'd6,  32'h0012_3456, 4'd6, 1'b0, 1'b0);
      set_vec(20, 5'd7,  32'h0123_4567, 4'd7, 1'b0, 1'b0);
      set_vec(21, 5'd8,  32'h1234_5678, 4'd8, 1'b0, 1'b0);
      set_vec(22, 5'd9,  32'h1234_5678, 4'd8, 1'b1, 1'b0);
      set_vec(23, 5'd16, 32'h1234_5678, 4'd8, 1'b1, 1'b0);
      set_vec(24, 5'd3,  32'h1234_5678, 4'd8, 1'b1, 1'b0);
      set_vec(25, 5'd18, 32'h0000_0000, 4'd0, 1'b0, 1'b0);

      reset = 1'b1; key_code = '0; key_strobe = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset_entry", entry_value, 32'h0);
      check("reset_count", 32'(digit_count), 32'h0);
      check("reset_valid", 32'(out_valid), 32'h0);
      check("reset_outval", out_value, 32'h0);
      check("reset_ovf", 32'(overflow), 32'h0);

      for (int i = 0; i < 26; i++) begin
         press(tbl[i].code);
         check($sformatf("vec%0d_entry", i), entry_value, tbl[i].exp_entry);
         check($sformatf("vec%0d_count", i), 32'(digit_count), 32'(tbl[i].exp_count));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      end

      // long hold with a short mid-press glitch yields a single digit
      key_code = 5'd7; key_strobe = 1'b1;
      repeat (4) @(negedge clock);
      key_strobe = 1'b0;
      repeat (2) @(negedge clock);
      key_strobe = 1'b1;
      repeat (4) @(negedge clock);
      key_strobe = 1'b0;
      repeat (4) @(negedge clock);
      check("glitch_entry", entry_value, 32'h7);
      check("glitch_count", 32'(digit_count), 32'd1);

      // ENTER then back-pressure; events during HOLD are discarded
      press(5'd3);
      press(5'd16);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_outval", out_value, 32'h73);
      press(5'd9);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("hold%0d_outval", c), out_value, 32'h73);
         check($sformatf("hold%0d_entry", c), entry_value, 32'h73);
         @(negedge clock);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check("hs_valid", 32'(out_valid), 32'd0);
      check("hs_entry", entry_value, 32'h0);
      check("hs_count", 32'(digit_count), 32'd0);
      check("hs_outval_kept", out_value, 32'h73);
      press(5'd4);
      check("post_hs_entry", entry_value, 32'h4);

      // reset while HOLD clears everything immediately
      press(5'd16);
      check("hold2_valid", 32'(out_valid), 32'd1);
      key_code = 5'd2; key_strobe = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("rst_hold_valid", 32'(out_valid), 32'd0);
      check("rst_hold_outval", out_value, 32'h0);
      check("rst_hold_entry", entry_value, 32'h0);
      check("rst_hold_count", 32'(digit_count), 32'd0);
      key_strobe = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      press(5'd6);
      check("rst_first_press_entry", entry_value, 32'h6);
      check("rst_first_press_count", 32'(digit_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
